// File: rtl/regfile_arbiter.sv
// Two-requester front end for an external 16x8 register file: init, arbitrate, issue, return.
// Define RFARB_ROUND_ROBIN_EN to alternate simultaneous winners; otherwise requester A has priority.
module regfile_arbiter (
    input  logic       clk,
    input  logic       Rst,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       a_wr,
    input  logic       b_wr,
    input  logic [3:0] a_waddr,
    input  logic [3:0] b_waddr,
    input  logic [7:0] a_wdata,
    input  logic [7:0] b_wdata,
    input  logic [3:0] a_raddr1,
    input  logic [3:0] a_raddr2,
    input  logic [3:0] b_raddr1,
    input  logic [3:0] b_raddr2,
    output logic       a_gnt,
    output logic       b_gnt,
    output logic       a_rvalid,
    output logic       b_rvalid,
    output logic [7:0] rdata1,
    output logic [7:0] rdata2,
    output logic [7:0] rf_Datain,
    output logic [3:0] rf_AddressW,
    output logic [3:0] rf_AddressR1,
    output logic [3:0] rf_AddressR2,
    output logic       rf_W,
    output logic       rf_R,
    output logic       rf_Rst,
    input  logic [7:0] rf_Dataout1,
    input  logic [7:0] rf_Dataout2
);

    typedef enum logic [2:0] {
        INIT0 = 3'd0,
        INIT1 = 3'd1,
        IDLE  = 3'd2,
        ISSUE = 3'd3,
        RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic       wr;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic [3:0] raddr1;
        logic [3:0] raddr2;
        logic       winB;
    } cmd_t;

    state_t     state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic [7:0] rdata2_q, rdata2_d;
    logic       pickB;

`ifdef RFARB_ROUND_ROBIN_EN
    // lastWinB_q is 1 when B won the most recent grant
    logic lastWinB_q, lastWinB_d;

    always_comb begin
        pickB = b_req && (!a_req || !lastWinB_q);
    end
`else
    always_comb begin
        pickB = b_req && !a_req;
    end
`endif

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= INIT0;
            cmd_q      <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
`ifdef RFARB_ROUND_ROBIN_EN
            lastWinB_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
`ifdef RFARB_ROUND_ROBIN_EN
            lastWinB_q <= lastWinB_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        rdata1_d     = rdata1_q;
        rdata2_d     = rdata2_q;
`ifdef RFARB_ROUND_ROBIN_EN
        lastWinB_d   = lastWinB_q;
`endif
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        a_rvalid     = 1'b0;
        b_rvalid     = 1'b0;
        rdata1       = rdata1_q;
        rdata2       = rdata2_q;
        rf_Datain    = 8'h00;
        rf_AddressW  = 4'h0;
        rf_AddressR1 = 4'h0;
        rf_AddressR2 = 4'h0;
        rf_W         = 1'b0;
        rf_R         = 1'b0;
        rf_Rst       = 1'b0;

        case (state_q)
            INIT0: begin
                rf_Rst  = 1'b1;
                state_d = INIT1;
            end
            INIT1: begin
                rf_Rst  = 1'b1;
                state_d = IDLE;
            end
            IDLE: begin
                if (a_req || b_req) begin
                    cmd_d.winB   = pickB;
                    cmd_d.wr     = pickB ? b_wr     : a_wr;
                    cmd_d.waddr  = pickB ? b_waddr  : a_waddr;
                    cmd_d.wdata  = pickB ? b_wdata  : a_wdata;
                    cmd_d.raddr1 = pickB ? b_raddr1 : a_raddr1;
                    cmd_d.raddr2 = pickB ? b_raddr2 : a_raddr2;
`ifdef RFARB_ROUND_ROBIN_EN
                    lastWinB_d   = pickB;
`endif
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // Register file reads before it writes on this edge, so a same-address read sees old data
                rf_AddressW  = cmd_q.waddr;
                rf_Datain    = cmd_q.wdata;
                rf_AddressR1 = cmd_q.raddr1;
                rf_AddressR2 = cmd_q.raddr2;
                rf_W         = cmd_q.wr;
                rf_R         = 1'b1;
                a_gnt        = !cmd_q.winB;
                b_gnt        = cmd_q.winB;
                state_d      = RESP;
            end
            RESP: begin
                rdata1   = rf_Dataout1;
                rdata2   = rf_Dataout2;
                rdata1_d = rf_Dataout1;
                rdata2_d = rf_Dataout2;
                a_rvalid = !cmd_q.winB;
                b_rvalid = cmd_q.winB;
                state_d  = IDLE;
            end
            default: begin
                state_d = INIT0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural register file attached to the rf_* ports.
module tb_regfile_arbiter;

   logic       clk = 1'b0;
   logic       Rst;
   logic       a_req, b_req, a_wr, b_wr;
   logic [3:0] a_waddr, b_waddr, a_raddr1, a_raddr2, b_raddr1, b_raddr2;
   logic [7:0] a_wdata, b_wdata;
   logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [7:0] rdata1, rdata2, rf_Datain, rf_Dataout1, rf_Dataout2;
   logic [3:0] rf_AddressW, rf_AddressR1, rf_AddressR2;
   logic       rf_W, rf_R, rf_Rst;

   typedef struct packed {
      logic       who;
      logic [7:0] d1;
      logic [7:0] d2;
   } resp_t;

   logic  gntQ[$];
   resp_t respQ[$];
   int    checks = 0;
   int    passes = 0;
   int    cycle = 0;
   int    bGntCount = 0;
   int    aRvalidCount = 0;
   logic [7:0] mem [16];

   always #5 clk = ~clk;

   // Clock counter used to measure grant spacing
   always @(posedge clk) cycle++;

   regfile_arbiter dut (
      .clk(clk), .Rst(Rst),
      .a_req(a_req), .b_req(b_req), .a_wr(a_wr), .b_wr(b_wr),
      .a_waddr(a_waddr), .b_waddr(b_waddr), .a_wdata(a_wdata), .b_wdata(b_wdata),
      .a_raddr1(a_raddr1), .a_raddr2(a_raddr2), .b_raddr1(b_raddr1), .b_raddr2(b_raddr2),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
      .rdata1(rdata1), .rdata2(rdata2),
      .rf_Datain(rf_Datain), .rf_AddressW(rf_AddressW),
      .rf_AddressR1(rf_AddressR1), .rf_AddressR2(rf_AddressR2),
      .rf_W(rf_W), .rf_R(rf_R), .rf_Rst(rf_Rst),
      .rf_Dataout1(rf_Dataout1), .rf_Dataout2(rf_Dataout2)
   );

   // Register file model: sync active-high reset, registered reads that see pre-write contents
   always @(posedge clk) begin
      if (rf_Rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
         rf_Dataout1 <= 8'h00;
         rf_Dataout2 <= 8'h00;
      end else begin
         if (rf_R) begin
            rf_Dataout1 <= mem[rf_AddressR1];
            rf_Dataout2 <= mem[rf_AddressR2];
         end
         if (rf_W) mem[rf_AddressW] <= rf_Datain;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
   endtask

   // Monitor: pops the scoreboard whenever the DUT pulses a grant or read-valid
   always @(negedge clk) begin
      if (a_gnt || b_gnt) begin
         if (b_gnt) bGntCount++;
         if (gntQ.size() == 0) checkOutput("gnt_unexpected", {a_gnt, b_gnt}, 2'b00);
         else begin
            automatic logic e = gntQ.pop_front();
            checkOutput("gnt_order", {a_gnt, b_gnt}, e ? 2'b01 : 2'b10);
         end
      end
      if (a_rvalid || b_rvalid) begin
         if (a_rvalid) aRvalidCount++;
         if (respQ.size() == 0) checkOutput("rvalid_unexpected", {a_rvalid, b_rvalid}, 2'b00);
         else begin
            automatic resp_t r = respQ.pop_front();
            checkOutput("rvalid_who", {a_rvalid, b_rvalid}, r.who ? 2'b01 : 2'b10);
            checkOutput("rdata", {rdata1, rdata2}, {r.d1, r.d2});
         end
      end
   end

   task automatic applyStimulus(input logic who, input logic wr, input logic [3:0] waddr,
                                input logic [7:0] wdata, input logic [3:0] r1, input logic [3:0] r2);
      if (who) begin
         b_wr = wr; b_waddr = waddr; b_wdata = wdata; b_raddr1 = r1; b_raddr2 = r2; b_req = 1'b1;
      end else begin
         a_wr = wr; a_waddr = waddr; a_wdata = wdata; a_raddr1 = r1; a_raddr2 = r2; a_req = 1'b1;
      end
   endtask

   task automatic expectTxn(input logic who, input logic [7:0] d1, input logic [7:0] d2);
      gntQ.push_back(who);
      respQ.push_back('{who: who, d1: d1, d2: d2});
   endtask

   // which: 0 = A, 1 = B, 2 = either; returns #1 after the grant edge
   task automatic waitGnt(input int which);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         if ((which == 0 && a_gnt) || (which == 1 && b_gnt) || (which == 2 && (a_gnt || b_gnt)))
            got = 1'b1;
      end
      checkOutput("gnt_wait", got, 1'b1);
   endtask

   task automatic runTxn(input logic who, input logic wr, input logic [3:0] waddr, input logic [7:0] wdata,
                         input logic [3:0] r1, input logic [3:0] r2, input logic [7:0] d1, input logic [7:0] d2);
      expectTxn(who, d1, d2);
      applyStimulus(who, wr, waddr, wdata, r1, r2);
      waitGnt(who ? 1 : 0);
      if (who) b_req = 1'b0; else a_req = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int gc, bBefore, aBefore;
      logic simOrder[4];
      Rst = 1'b0;
      a_req = 0; b_req = 0; a_wr = 0; b_wr = 0;
      a_waddr = 0; b_waddr = 0; a_wdata = 0; b_wdata = 0;
      a_raddr1 = 0; a_raddr2 = 0; b_raddr1 = 0; b_raddr2 = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_rf_Rst", rf_Rst, 1'b1);
      checkOutput("reset_gnt_rvalid", {a_gnt, b_gnt, a_rvalid, b_rvalid}, 4'h0);
      checkOutput("reset_rf_en", {rf_W, rf_R}, 2'b00);
      checkOutput("reset_rf_bus", {rf_AddressW, rf_AddressR1, rf_AddressR2, rf_Datain}, 20'h0);
      checkOutput("reset_rdata", {rdata1, rdata2}, 16'h0);

      // A writes 5A to r3 and reads r3/r0 in the same transaction, request held through init
      expectTxn(1'b0, 8'h00, 8'h00);
      applyStimulus(1'b0, 1'b1, 4'd3, 8'h5A, 4'd3, 4'd0);
      @(negedge clk) Rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("init1_rf_Rst", rf_Rst, 1'b1);
      checkOutput("init1_no_gnt", a_gnt, 1'b0);
      @(posedge clk); #1;
      checkOutput("idle_rf_Rst", rf_Rst, 1'b0);
      checkOutput("idle_no_gnt", a_gnt, 1'b0);
      checkOutput("idle_rf_en", {rf_W, rf_R}, 2'b00);
      @(posedge clk); #1;
      checkOutput("first_gnt", a_gnt, 1'b1);
      checkOutput("issue_rf_en", {rf_W, rf_R}, 2'b11);
      checkOutput("issue_rf_bus", {rf_AddressW, rf_Datain, rf_AddressR1, rf_AddressR2}, 20'h35A30);
      a_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("resp_rf_en", {rf_W, rf_R}, 2'b00);
      @(posedge clk); #1;

      // Follow-up read sees the new value, then it must hold in IDLE
      runTxn(1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 8'h5A, 8'h5A);
      checkOutput("rdata_hold", {rdata1, rdata2}, 16'h5A5A);

      // Lone B wins
      runTxn(1'b1, 1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 8'h5A, 8'h5A);

      // Simultaneous requests for four transactions
`ifdef RFARB_ROUND_ROBIN_EN
      simOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      simOrder = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int k = 0; k < 4; k++) begin
         if (simOrder[k]) expectTxn(1'b1, 8'h00, 8'h5A);
         else expectTxn(1'b0, 8'h5A, 8'h00);
      end
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd0);
      applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 4'd3);
      for (int k = 0; k < 4; k++) waitGnt(2);
      a_req = 1'b0;
      b_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Back-to-back B: grant every third cycle, rvalid one cycle after each grant
      for (int k = 0; k < 3; k++) expectTxn(1'b1, 8'h5A, 8'h00);
      applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 4'd3, 4'd0);
      waitGnt(1);
      gc = cycle;
      @(posedge clk); #1;
      checkOutput("b2b_rvalid_lat", b_rvalid, 1'b1);
      for (int k = 0; k < 2; k++) begin
         waitGnt(1);
         checkOutput("b2b_spacing", cycle - gc, 3);
         gc = cycle;
         @(posedge clk); #1;
         checkOutput("b2b_rvalid_lat", b_rvalid, 1'b1);
      end
      b_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // B pulses its request only while A is in ISSUE: must be ignored
      bBefore = bGntCount;
      expectTxn(1'b0, 8'h00, 8'h5A);
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd3);
      waitGnt(0);
      a_req = 1'b0;
      b_req = 1'b1;
      @(posedge clk); #1;
      b_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("short_breq_no_gnt", bGntCount - bBefore, 0);

      // Reset pulsed during RESP of an A transaction aborts it and clears the register file
      gntQ.push_back(1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd3);
      waitGnt(0);
      a_req = 1'b0;
      @(posedge clk); #1;
      aBefore = aRvalidCount;
      Rst = 1'b0;
      #1;
      checkOutput("async_reset_rvalid", a_rvalid, 1'b0);
      checkOutput("async_reset_rf_Rst", rf_Rst, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk) Rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("aborted_no_rvalid", aRvalidCount - aBefore, 0);
      runTxn(1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 8'h00, 8'h00);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("gntQ_drained", gntQ.size(), 0);
      checkOutput("respQ_drained", respQ.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
